egg_timer_ctrl: RTL and testbench
=================================

EGG_TIMER_CTRL -- requirements
Module: egg_timer_ctrl

Interface
REQ-001 Parameter MAX_MINS, default 99, highest settable minutes value (BCD, 1..99).
REQ-002 Parameter ALARM_TICKS, default 10, alarm duration in 1 Hz ticks (used only with ALARM_TIMEOUT_EN).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 tick_1hz  input  1  one-cycle pulse per second, clk-synchronous.
REQ-006 cook_time  input  1  level; high = time-configuration mode.
REQ-007 start  input  1  debounced one-cycle pulse; start/pause toggle, alarm acknowledge.
REQ-008 mins_inc  input  1  debounced one-cycle pulse; add one minute.
REQ-009 secs_inc  input  1  debounced one-cycle pulse; add one second.
REQ-010 enable  input  1  level; low freezes countdown and ignores buttons.
REQ-011 mins_bcd  output  8  current minutes, two BCD digits.
REQ-012 secs_bcd  output  8  current seconds, two BCD digits.
REQ-013 running  output  1  high in RUN.
REQ-014 alarm  output  1  high in ALARM.
REQ-015 state_o  output  3  encoded state for display/debug.

Function
REQ-016 States SHALL be IDLE, SET, PAUSED, RUN, ALARM; all outputs registered, updated on the same edge that samples the causing input (latency 1 clk).
REQ-017 Input priority per cycle SHALL be: enable low > cook_time > start > tick_1hz > mins_inc/secs_inc.
REQ-018 IDLE: cook_time -> SET; start with time != 00:00 -> RUN; start at 00:00 ignored.
REQ-019 SET: mins_inc adds 1 minute, MAX_MINS wraps to 00; secs_inc adds 1 second, 59 wraps to 00 with no carry; ticks ignored.
REQ-020 SET exit on cook_time low: -> PAUSED if time != 00:00, else IDLE.
REQ-021 PAUSED: start -> RUN; cook_time -> SET; time held.
REQ-022 RUN: tick decrements time; secs 00 with mins > 0 -> secs 59, mins - 1.
REQ-023 RUN: tick at 00:01 SHALL produce 00:00 and ALARM on the same edge.
REQ-024 RUN: start -> PAUSED with tick in same cycle discarded; cook_time -> SET with time preserved.
REQ-025 ALARM: start or cook_time rising -> IDLE; time stays 00:00.
REQ-026 enable low: RUN -> PAUSED; all other states hold; ticks and button pulses discarded; enable return does not resume automatically.
REQ-027 mins_inc and secs_inc in the same SET cycle SHALL both apply.
REQ-028 Illegal state encoding SHALL recover to IDLE on next edge.

Reset
REQ-029 rst low at a rising clk edge SHALL force IDLE, mins_bcd=00, secs_bcd=00, running=0, alarm=0, state_o=IDLE, alarm counter=0, regardless of state or in-flight inputs.

Configuration
REQ-030 Macro ALARM_TIMEOUT_EN defined: ALARM auto-returns to IDLE on the ALARM_TICKS-th tick after entry; start/cook_time still clear earlier.
REQ-031 ALARM_TIMEOUT_EN undefined: ALARM holds indefinitely until start or cook_time; no alarm counter logic instantiated.

Structure
REQ-032 Shared package egg_timer_pkg SHALL hold the state enumeration, state_o encoding, and the constants 59 and default MAX_MINS.
REQ-033 Sub-module bcd_mmss_counter SHALL implement the BCD mm:ss register with load-zero, inc-minute, inc-second, and decrement operations; egg_timer_ctrl holds the FSM and alarm counter.

Verification
REQ-034 Reset, cook_time=1, 3x mins_inc, 30x secs_inc, cook_time=0 -> PAUSED, 03:30.
REQ-035 From 00:02 PAUSED, start then 2 ticks -> 00:01 then 00:00 with alarm=1 on the 2nd tick edge; start -> IDLE.
REQ-036 RUN at 01:00, one tick -> 00:59; start and tick in same cycle at 00:59 -> PAUSED, 00:59.
REQ-037 SET at 99:59, mins_inc+secs_inc same cycle -> 00:00; cook_time=0 -> IDLE.
REQ-038 RUN at 00:10, enable=0 for 5 ticks -> PAUSED, 00:10; enable=1 -> still PAUSED.
REQ-039 ALARM with ALARM_TIMEOUT_EN, ALARM_TICKS=10 -> IDLE on 10th tick; without macro, alarm=1 after 20 ticks; rst low mid-RUN -> IDLE, 00:00 next edge.

Source files
------------

// File: rtl/egg_timer_pkg.sv
// Shared types and constants for the egg timer: state encoding (also driven on state_o),
// BCD limits and small BCD digit helpers.
package egg_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SET    = 3'd1,
    ST_PAUSED = 3'd2,
    ST_RUN    = 3'd3,
    ST_ALARM  = 3'd4
  } state_e;

  localparam int unsigned SECS_MAX     = 59;
  localparam int unsigned DEF_MAX_MINS = 99;

  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// BCD mm:ss time register: clear, independent minute/second increment with wrap, and
// one-second decrement with borrow from minutes.
module bcd_mmss_counter
  import egg_timer_pkg::*;
#(
  parameter int unsigned MAX_MINS = DEF_MAX_MINS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       inc_min_i,
  input  logic       inc_sec_i,
  input  logic       dec_i,
  output logic [7:0] mins_o,
  output logic [7:0] secs_o,
  output logic       zero_o,
  output logic       one_o
);

  localparam logic [7:0] MINS_TOP = to_bcd(MAX_MINS);
  localparam logic [7:0] SECS_TOP = to_bcd(SECS_MAX);

  logic [7:0] mins_q, mins_d, secs_q, secs_d;

  assign zero_o = (mins_q == 8'h00) && (secs_q == 8'h00);
  assign one_o  = (mins_q == 8'h00) && (secs_q == 8'h01);
  assign mins_o = mins_q;
  assign secs_o = secs_q;

  always_comb begin
    mins_d = mins_q;
    secs_d = secs_q;
    if (clr_i) begin
      mins_d = 8'h00;
      secs_d = 8'h00;
    end else if (dec_i && !zero_o) begin
      if (secs_q == 8'h00) begin
        secs_d = SECS_TOP;
        mins_d = bcd_dec(mins_q);
      end else begin
        secs_d = bcd_dec(secs_q);
      end
    end else begin
      // Setting increments wrap independently; seconds never carry into minutes.
      if (inc_min_i) mins_d = (mins_q >= MINS_TOP) ? 8'h00 : bcd_inc(mins_q);
      if (inc_sec_i) secs_d = (secs_q >= SECS_TOP) ? 8'h00 : bcd_inc(secs_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mins_q <= 8'h00;
      secs_q <= 8'h00;
    end else begin
      mins_q <= mins_d;
      secs_q <= secs_d;
    end
  end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer control FSM (IDLE/SET/PAUSED/RUN/ALARM) around a BCD mm:ss counter.
// Define ALARM_TIMEOUT_EN to let ALARM fall back to IDLE after ALARM_TICKS seconds.
module egg_timer_ctrl
  import egg_timer_pkg::*;
#(
  parameter int unsigned MAX_MINS    = DEF_MAX_MINS,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       cook_time,
  input  logic       start,
  input  logic       mins_inc,
  input  logic       secs_inc,
  input  logic       enable,
  output logic [7:0] mins_bcd,
  output logic [7:0] secs_bcd,
  output logic       running,
  output logic       alarm,
  output logic [2:0] state_o
);

  if (MAX_MINS < 1 || MAX_MINS > 99 || ALARM_TICKS < 1) begin : g_param_chk
    $error("egg_timer_ctrl: MAX_MINS must be 1..99 and ALARM_TICKS >= 1");
  end

  state_e state_q, state_d;
  logic   running_q, alarm_q, cook_q;
  logic   inc_m, inc_s, dec, t_zero, t_one;

`ifdef ALARM_TIMEOUT_EN
  localparam int ACW = $clog2(ALARM_TICKS + 1);
  logic [ACW-1:0] alm_cnt_q, alm_cnt_d;
`endif

  bcd_mmss_counter #(.MAX_MINS(MAX_MINS)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (1'b0),
    .inc_min_i (inc_m),
    .inc_sec_i (inc_s),
    .dec_i     (dec),
    .mins_o    (mins_bcd),
    .secs_o    (secs_bcd),
    .zero_o    (t_zero),
    .one_o     (t_one)
  );

  always_comb begin
    state_d = state_q;
    inc_m   = 1'b0;
    inc_s   = 1'b0;
    dec     = 1'b0;
`ifdef ALARM_TIMEOUT_EN
    alm_cnt_d = alm_cnt_q;
`endif
    if (!enable) begin
      case (state_q)
        ST_RUN:                                   state_d = ST_PAUSED;
        ST_IDLE, ST_SET, ST_PAUSED, ST_ALARM:     state_d = state_q;
        default:                                  state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cook_time)              state_d = ST_SET;
          else if (start && !t_zero)  state_d = ST_RUN;
        end
        ST_SET: begin
          if (!cook_time) begin
            state_d = t_zero ? ST_IDLE : ST_PAUSED;
          end else begin
            inc_m = mins_inc;
            inc_s = secs_inc;
          end
        end
        ST_PAUSED: begin
          if (cook_time)   state_d = ST_SET;
          else if (start)  state_d = ST_RUN;
        end
        ST_RUN: begin
          if (cook_time)      state_d = ST_SET;
          else if (start)     state_d = ST_PAUSED;
          else if (tick_1hz) begin
            dec = 1'b1;
            if (t_one) state_d = ST_ALARM;
          end
        end
        ST_ALARM: begin
          // Only a fresh cook_time press acknowledges; a level held from before does not.
          if ((cook_time && !cook_q) || start) state_d = ST_IDLE;
`ifdef ALARM_TIMEOUT_EN
          else if (tick_1hz) begin
            if (alm_cnt_q == ACW'(ALARM_TICKS - 1)) state_d = ST_IDLE;
            else                                    alm_cnt_d = alm_cnt_q + 1'b1;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef ALARM_TIMEOUT_EN
    if (state_d != ST_ALARM) alm_cnt_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      cook_q    <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
      alm_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
      alarm_q   <= (state_d == ST_ALARM);
      cook_q    <= cook_time;
`ifdef ALARM_TIMEOUT_EN
      alm_cnt_q <= alm_cnt_d;
`endif
    end
  end

  assign running = running_q;
  assign alarm   = alarm_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed self-checking bench for egg_timer_ctrl (default parameters).
module tb_egg_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0, cook_time = 1'b0, start = 1'b0;
  logic       mins_inc = 1'b0, secs_inc = 1'b0, enable = 1'b1;
  logic [7:0] mins_bcd, secs_bcd;
  logic       running, alarm;
  logic [2:0] state_o;
  int         errs = 0, checks = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_PAUSED = 3'd2, S_RUN = 3'd3, S_ALARM = 3'd4;

  egg_timer_ctrl #(.MAX_MINS(99), .ALARM_TICKS(10)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .cook_time(cook_time), .start(start),
    .mins_inc(mins_inc), .secs_inc(secs_inc), .enable(enable),
    .mins_bcd(mins_bcd), .secs_bcd(secs_bcd), .running(running), .alarm(alarm), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // One clock with the given pulses; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic st, input logic mi, input logic si, input logic tk);
    start = st; mins_inc = mi; secs_inc = si; tick_1hz = tk;
    @(posedge clk); #1;
    start = 1'b0; mins_inc = 1'b0; secs_inc = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; cook_time = 1'b0; enable = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state_o !== S_IDLE) begin errs++; $display("FAIL reset_state got=%0d want=%0d", state_o, S_IDLE); end
    checks++; if ({mins_bcd, secs_bcd} !== 16'h0000) begin errs++; $display("FAIL reset_time got=%h want=0000", {mins_bcd, secs_bcd}); end
    checks++; if ({running, alarm} !== 2'b00) begin errs++; $display("FAIL reset_flags got=%b want=00", {running, alarm}); end
    step(1, 0, 0, 0);
    checks++; if (state_o !== S_IDLE) begin errs++; $display("FAIL idle_start_zero got=%0d want=%0d", state_o, S_IDLE); end
  endtask

  task automatic test_set();
    do_reset();
    cook_time = 1'b1; step(0, 0, 0, 0);
    checks++; if (state_o !== S_SET) begin errs++; $display("FAIL enter_set got=%0d want=%0d", state_o, S_SET); end
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 1, 0);
    checks++; if ({mins_bcd, secs_bcd} !== 16'h0330) begin errs++; $display("FAIL set_time got=%h want=0330", {mins_bcd, secs_bcd}); end
    step(0, 0, 0, 1);
    checks++; if (secs_bcd !== 8'h30) begin errs++; $display("FAIL set_tick_ignored got=%h want=30", secs_bcd); end
    cook_time = 1'b0; step(0, 0, 0, 0);
    checks++; if ({state_o, mins_bcd, secs_bcd} !== {S_PAUSED, 16'h0330}) begin errs++; $display("FAIL set_exit got=%0d %h want=%0d 0330", state_o, {mins_bcd, secs_bcd}, S_PAUSED); end
  endtask

  // Program 00:01 and start it, so the next tick raises the alarm.
  task automatic arm_one_sec();
    cook_time = 1'b1; step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    cook_time = 1'b0; step(0, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic test_alarm();
    do_reset();
    cook_time = 1'b1; step(0, 0, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    cook_time = 1'b0; step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    checks++; if ({state_o, running} !== {S_RUN, 1'b1}) begin errs++; $display("FAIL run_start got=%0d/%b want=%0d/1", state_o, running, S_RUN); end
    step(0, 0, 0, 1);
    checks++; if ({mins_bcd, secs_bcd, alarm} !== {16'h0001, 1'b0}) begin errs++; $display("FAIL tick_to_0001 got=%h a=%b want=0001 a=0", {mins_bcd, secs_bcd}, alarm); end
    step(0, 0, 0, 1);
    checks++; if ({state_o, mins_bcd, secs_bcd, alarm, running} !== {S_ALARM, 16'h0000, 2'b10}) begin errs++; $display("FAIL alarm_entry got=%0d %h a=%b r=%b want=4 0000 a=1 r=0", state_o, {mins_bcd, secs_bcd}, alarm, running); end
    step(1, 0, 0, 0);
    checks++; if ({state_o, alarm, mins_bcd, secs_bcd} !== {S_IDLE, 1'b0, 16'h0000}) begin errs++; $display("FAIL alarm_ack_start got=%0d a=%b %h want=0 a=0 0000", state_o, alarm, {mins_bcd, secs_bcd}); end
    arm_one_sec();
    step(0, 0, 0, 1);
    checks++; if (state_o !== S_ALARM) begin errs++; $display("FAIL alarm_reentry got=%0d want=%0d", state_o, S_ALARM); end
`ifdef ALARM_TIMEOUT_EN
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
    checks++; if (alarm !== 1'b1) begin errs++; $display("FAIL alarm_9_ticks got=%b want=1", alarm); end
    step(0, 0, 0, 1);
    checks++; if ({state_o, alarm} !== {S_IDLE, 1'b0}) begin errs++; $display("FAIL alarm_timeout got=%0d a=%b want=0 a=0", state_o, alarm); end
`else
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
    checks++; if ({state_o, alarm} !== {S_ALARM, 1'b1}) begin errs++; $display("FAIL alarm_hold_20 got=%0d a=%b want=4 a=1", state_o, alarm); end
    cook_time = 1'b1; step(0, 0, 0, 0);
    checks++; if ({state_o, alarm} !== {S_IDLE, 1'b0}) begin errs++; $display("FAIL alarm_ack_cook got=%0d a=%b want=0 a=0", state_o, alarm); end
    cook_time = 1'b0;
`endif
  endtask

  task automatic test_decrement();
    do_reset();
    cook_time = 1'b1; step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    cook_time = 1'b0; step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    checks++; if ({mins_bcd, secs_bcd} !== 16'h0059) begin errs++; $display("FAIL borrow got=%h want=0059", {mins_bcd, secs_bcd}); end
    step(1, 0, 0, 1);
    checks++; if ({state_o, mins_bcd, secs_bcd} !== {S_PAUSED, 16'h0059}) begin errs++; $display("FAIL pause_drops_tick got=%0d %h want=2 0059", state_o, {mins_bcd, secs_bcd}); end
    step(1, 0, 0, 0);
    cook_time = 1'b1; step(0, 0, 0, 1);
    checks++; if ({state_o, mins_bcd, secs_bcd} !== {S_SET, 16'h0059}) begin errs++; $display("FAIL run_to_set got=%0d %h want=1 0059", state_o, {mins_bcd, secs_bcd}); end
    cook_time = 1'b0; step(0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    do_reset();
    cook_time = 1'b1; step(0, 0, 0, 0);
    for (int i = 0; i < 99; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 59; i++) step(0, 0, 1, 0);
    checks++; if ({mins_bcd, secs_bcd} !== 16'h9959) begin errs++; $display("FAIL set_max got=%h want=9959", {mins_bcd, secs_bcd}); end
    step(0, 1, 1, 0);
    checks++; if ({mins_bcd, secs_bcd} !== 16'h0000) begin errs++; $display("FAIL dual_wrap got=%h want=0000", {mins_bcd, secs_bcd}); end
    cook_time = 1'b0; step(0, 0, 0, 0);
    checks++; if (state_o !== S_IDLE) begin errs++; $display("FAIL set_exit_zero got=%0d want=%0d", state_o, S_IDLE); end
  endtask

  task automatic test_enable();
    do_reset();
    cook_time = 1'b1; step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    cook_time = 1'b0; step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    enable = 1'b0; step(0, 0, 0, 1);
    checks++; if ({state_o, running, secs_bcd} !== {S_PAUSED, 1'b0, 8'h10}) begin errs++; $display("FAIL enable_low_pause got=%0d r=%b s=%h want=2 r=0 s=10", state_o, running, secs_bcd); end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(1, 1, 1, 0);
    checks++; if ({state_o, mins_bcd, secs_bcd} !== {S_PAUSED, 16'h0010}) begin errs++; $display("FAIL enable_low_hold got=%0d %h want=2 0010", state_o, {mins_bcd, secs_bcd}); end
    enable = 1'b1; step(0, 0, 0, 1);
    checks++; if ({state_o, mins_bcd, secs_bcd} !== {S_PAUSED, 16'h0010}) begin errs++; $display("FAIL enable_return got=%0d %h want=2 0010", state_o, {mins_bcd, secs_bcd}); end
  endtask

  task automatic test_reset_midrun();
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    checks++; if ({state_o, secs_bcd} !== {S_RUN, 8'h09}) begin errs++; $display("FAIL midrun_pre got=%0d s=%h want=3 s=09", state_o, secs_bcd); end
    rst = 1'b0; step(1, 1, 1, 1);
    checks++; if ({state_o, mins_bcd, secs_bcd, running, alarm} !== {S_IDLE, 16'h0000, 2'b00}) begin errs++; $display("FAIL midrun_reset got=%0d %h r=%b a=%b want=0 0000 r=0 a=0", state_o, {mins_bcd, secs_bcd}, running, alarm); end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_set();
    test_alarm();
    test_decrement();
    test_wrap();
    test_enable();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
